// File: rtl/mskaes_pkg.sv
// Shared definitions for the masked AES output path: block size, FSM encoding
// and width helpers.
package mskaes_pkg;

   localparam int AES_BLOCK_BITS = 128;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   // Index width that never collapses to zero bits when only one word exists.
   function automatic int idx_w(input int nw);
      return (nw > 1) ? clog2(nw) : 1;
   endfunction

endpackage

// File: rtl/mskaes_out_serializer_if.sv
// Ciphertext-in / masked-word-out bus of the serializer. Sharings use the
// interleaved layout: bit i, share j at index i*d+j.
interface mskaes_out_serializer_if #(
   parameter int d = 2,
   parameter int W = 32
);
   localparam int NW = mskaes_pkg::AES_BLOCK_BITS / W;
   localparam int IW = mskaes_pkg::idx_w(NW);

   logic                                  cipher_valid;
   logic [mskaes_pkg::AES_BLOCK_BITS*d-1:0] sh_ciphertext;
   logic                                  in_ready;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [W*d-1:0]                        sh_word;
   logic [IW-1:0]                         word_idx;
   logic                                  last;
   logic                                  overflow;
   logic                                  clr_ovf;

   modport slave (
      input  cipher_valid, sh_ciphertext, out_ready, clr_ovf,
      output in_ready, out_valid, sh_word, word_idx, last, overflow
   );

   modport master (
      output cipher_valid, sh_ciphertext, out_ready, clr_ovf,
      input  in_ready, out_valid, sh_word, word_idx, last, overflow
   );
endinterface

// File: rtl/mskaes_msk_prims.sv
// Share-wise masking primitives: enabled register, 2:1 mux and constant
// sharing. None of them ever combines shares of the same bit.
module MSKregEn #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [count*d-1:0]   din,
   output logic [count*d-1:0]   dout
);
   logic [count*d-1:0] state_q, state_d;

   always_comb begin
      state_d = en ? din : state_q;
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   assign dout = state_q;
endmodule

module MSKmux #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic                 sel,
   input  logic [count*d-1:0]   in_true,
   input  logic [count*d-1:0]   in_false,
   output logic [count*d-1:0]   dout
);
   assign dout = sel ? in_true : in_false;
endmodule

module MSKcst #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic [count-1:0]     cst,
   output logic [count*d-1:0]   dout
);
   // A public constant lives entirely in share 0; the other shares are zero.
   for (genvar i = 0; i < count; i++) begin : g_bit
      assign dout[i*d] = cst[i];
      for (genvar j = 1; j < d; j++) begin : g_share
         assign dout[i*d+j] = 1'b0;
      end
   end
endmodule

// File: rtl/mskaes_out_serializer_word_select.sv
// NW:1 share-wise word mux over an interleaved 128-bit sharing.
module mskaes_word_select
   import mskaes_pkg::*;
#(
   parameter int d = 2,
   parameter int W = 32
) (
   input  logic [idx_w(AES_BLOCK_BITS/W)-1:0] sel,
   input  logic [AES_BLOCK_BITS*d-1:0]        sh_in,
   output logic [W*d-1:0]                     sh_out
);
   localparam int NW = AES_BLOCK_BITS / W;

   logic [NW-1:0][W*d-1:0] words;

   assign words = sh_in;

   if (NW == 1) begin : g_single
      assign sh_out = words[0];
   end else begin : g_multi
      assign sh_out = words[sel];
   end
endmodule

// File: rtl/mskaes_out_serializer.sv
// Captures the masked AES ciphertext sharing and streams it out as NW masked
// words over valid/ready, flagging ciphertexts that arrive while busy.
//
// state   | meaning
// ST_IDLE | buffer empty (zero sharing), ready for a ciphertext
// ST_SEND | buffer holds a sharing, word cnt_q is on the bus
module mskaes_out_serializer
   import mskaes_pkg::*;
#(
   parameter int d = 2,
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   mskaes_out_serializer_if.slave   bus
);
   localparam int NW = AES_BLOCK_BITS / W;
   localparam int IW = idx_w(NW);
   localparam int BW = AES_BLOCK_BITS * d;
   localparam int WW = W * d;

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic          is_send, at_last, beat, final_beat, rdy;
   logic          capture, drop, clear_buf, buf_en, buf_sel;
   logic [BW-1:0] zero_ct, buf_in, buf_q;
   logic [WW-1:0] zero_word, word_sel;

   assign is_send    = (state_q == ST_SEND);
   assign at_last    = (cnt_q == IW'(NW - 1));
   assign beat       = is_send && bus.out_ready;
   assign final_beat = beat && at_last;
   // The last beat frees the buffer in the same cycle, so a new block can land
   // without a bubble.
   assign rdy        = !is_send || final_beat;
   assign capture    = bus.cipher_valid && rdy;
   assign drop       = bus.cipher_valid && !rdy;
   assign clear_buf  = final_beat && !bus.cipher_valid;
   assign buf_en     = rst || capture || clear_buf;
   assign buf_sel    = capture && !rst;

   MSKcst #(.d(d), .count(AES_BLOCK_BITS)) u_zero_ct (
      .cst  ({AES_BLOCK_BITS{1'b0}}),
      .dout (zero_ct)
   );

   MSKmux #(.d(d), .count(AES_BLOCK_BITS)) u_buf_mux (
      .sel      (buf_sel),
      .in_true  (bus.sh_ciphertext),
      .in_false (zero_ct),
      .dout     (buf_in)
   );

   MSKregEn #(.d(d), .count(AES_BLOCK_BITS)) u_buf (
      .clk  (clk),
      .en   (buf_en),
      .din  (buf_in),
      .dout (buf_q)
   );

   mskaes_word_select #(.d(d), .W(W)) u_word_sel (
      .sel    (cnt_q),
      .sh_in  (buf_q),
      .sh_out (word_sel)
   );

   MSKcst #(.d(d), .count(W)) u_zero_word (
      .cst  ({W{1'b0}}),
      .dout (zero_word)
   );

   MSKmux #(.d(d), .count(W)) u_out_mux (
      .sel      (is_send),
      .in_true  (word_sel),
      .in_false (zero_word),
      .dout     (bus.sh_word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cipher_valid) begin
               state_d = ST_SEND;
               cnt_d   = '0;
            end
         end
         ST_SEND: begin
            if (final_beat) begin
               cnt_d   = '0;
               state_d = bus.cipher_valid ? ST_SEND : ST_IDLE;
            end else if (beat) begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = is_send;
   assign bus.word_idx  = cnt_q;
   assign bus.last      = at_last;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mskaes_out_serializer.sv
// Scoreboard bench for mskaes_out_serializer with d=2, W=32.
module tb_mskaes_out_serializer;
   import mskaes_pkg::*;

   localparam int D  = 2;
   localparam int W  = 32;
   localparam int NW = 4;
   localparam int BW = 128 * D;
   localparam int WW = W * D;

   localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C2 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RA = {16{8'hA5}};

   typedef struct {
      logic [31:0] word;
      logic [31:0] s0;
      int          idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mskaes_out_serializer_if #(.d(D), .W(W)) bus ();

   mskaes_out_serializer #(.d(D), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   sb_checks = 0;
   int   sb_errors = 0;
   exp_t sb_q[$];
   exp_t e;

   function automatic logic [BW-1:0] share(input logic [127:0] c, input logic [127:0] r);
      logic [BW-1:0] s;
      for (int i = 0; i < 128; i++) begin
         s[i*D]   = r[i];
         s[i*D+1] = c[i] ^ r[i];
      end
      return s;
   endfunction

   function automatic logic [31:0] unmask(input logic [WW-1:0] w);
      logic [31:0] u;
      for (int b = 0; b < W; b++) u[b] = w[b*D] ^ w[b*D+1];
      return u;
   endfunction

   function automatic logic [31:0] share0(input logic [WW-1:0] w);
      logic [31:0] u;
      for (int b = 0; b < W; b++) u[b] = w[b*D];
      return u;
   endfunction

   function automatic logic [31:0] share1(input logic [WW-1:0] w);
      logic [31:0] u;
      for (int b = 0; b < W; b++) u[b] = w[b*D+1];
      return u;
   endfunction

   // Scoreboard: every accepted beat is compared with the next expected word.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               sb_checks++; sb_errors++;
               $display("FAIL beat_unexpected: got idx=%0d word=%h, required no beat", bus.word_idx, unmask(bus.sh_word));
            end else begin
               e = sb_q.pop_front();
               sb_checks++;
               if (unmask(bus.sh_word) !== e.word) begin
                  sb_errors++;
                  $display("FAIL beat_word: got %h required %h (idx %0d)", unmask(bus.sh_word), e.word, e.idx);
               end
               sb_checks++;
               if (share0(bus.sh_word) !== e.s0) begin
                  sb_errors++;
                  $display("FAIL beat_share0: got %h required %h (idx %0d)", share0(bus.sh_word), e.s0, e.idx);
               end
               sb_checks++;
               if (bus.word_idx !== 2'(e.idx)) begin
                  sb_errors++;
                  $display("FAIL beat_idx: got %0d required %0d", bus.word_idx, e.idx);
               end
               sb_checks++;
               if (bus.last !== (e.idx == NW - 1)) begin
                  sb_errors++;
                  $display("FAIL beat_last: got %b required %b (idx %0d)", bus.last, (e.idx == NW - 1), e.idx);
               end
               sb_checks++;
               if (share0(bus.sh_word) === e.word || share1(bus.sh_word) === e.word) begin
                  sb_errors++;
                  $display("FAIL beat_lane_unmasked: got s0=%h s1=%h, required neither equal %h", share0(bus.sh_word), share1(bus.sh_word), e.word);
               end
            end
         end
         if (bus.out_valid === 1'b0) begin
            sb_checks++;
            if (bus.sh_word !== WW'(0)) begin
               sb_errors++;
               $display("FAIL idle_zero_word: got %h required 0", bus.sh_word);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [127:0] c, input logic [127:0] r);
      exp_t x;
      for (int k = 0; k < NW; k++) begin
         x.word = c[k*32 +: 32];
         x.s0   = r[k*32 +: 32];
         x.idx  = k;
         sb_q.push_back(x);
      end
   endtask

   // Called at posedge+1 while the serializer can accept.
   task automatic start(input logic [127:0] c, input logic [127:0] r);
      bus.cipher_valid  = 1'b1;
      bus.sh_ciphertext = share(c, r);
      push_exp(c, r);
      tick();
      bus.cipher_valid  = 1'b0;
   endtask

   task automatic drain(output bit timed_out);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (bus.out_valid !== 1'b0 && n < 30) begin
         tick();
         n++;
      end
      timed_out = (n >= 30);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cipher_valid  = 1'b0;
      bus.sh_ciphertext = '0;
      bus.out_ready     = 1'b1;
      bus.clr_ovf       = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
      checks++;
      if (bus.sh_word !== WW'(0)) begin errors++; $display("FAIL reset_sh_word: got %h required 0", bus.sh_word); end
      tick();
   endtask

   task automatic test_single();
      start(C1, RA);
      for (int k = 0; k < NW; k++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1 at beat %0d", bus.out_valid, k); end
         checks++;
         if (bus.last !== (k == NW - 1)) begin errors++; $display("FAIL single_last: got %b required %b at beat %0d", bus.last, (k == NW - 1), k); end
         checks++;
         if (bus.word_idx !== 2'(k)) begin errors++; $display("FAIL single_idx: got %0d required %0d", bus.word_idx, k); end
         tick();
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid: got %b required 0", bus.out_valid); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_done_in_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL single_leftover: got %0d pending required 0", sb_q.size()); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [WW-1:0] held;
      bit to;
      start(C1, RA);
      tick();
      bus.out_ready = 1'b0;
      @(negedge clk);
      held = bus.sh_word;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (bus.word_idx !== 2'd1) begin errors++; $display("FAIL bp_idx: got %0d required 1", bus.word_idx); end
         checks++;
         if (bus.sh_word !== held || unmask(bus.sh_word) !== C1[63:32]) begin
            errors++; $display("FAIL bp_hold: got %h required unmasked %h", unmask(bus.sh_word), C1[63:32]);
         end
         checks++;
         if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
         tick();
      end
      drain(to);
      checks++;
      if (to) begin errors++; $display("FAIL bp_timeout: got out_valid stuck required drained"); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d pending required 0", sb_q.size()); end
      tick();
   endtask

   task automatic test_back_to_back();
      bit to;
      start(C1, RA);
      tick();
      tick();
      tick();
      bus.cipher_valid  = 1'b1;
      bus.sh_ciphertext = share(C2, RA);
      push_exp(C2, RA);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready); end
      tick();
      bus.cipher_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.word_idx !== 2'd0) begin
         errors++; $display("FAIL b2b_no_bubble: got valid=%b idx=%0d required valid=1 idx=0", bus.out_valid, bus.word_idx);
      end
      drain(to);
      checks++;
      if (to) begin errors++; $display("FAIL b2b_timeout: got out_valid stuck required drained"); end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b required 0", bus.overflow); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d pending required 0", sb_q.size()); end
      tick();
   endtask

   task automatic test_drop();
      bit to;
      start(C1, RA);
      tick();
      bus.out_ready     = 1'b0;
      bus.cipher_valid  = 1'b1;
      bus.sh_ciphertext = share(C2, RA);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL drop_in_ready: got %b required 0", bus.in_ready); end
      tick();
      bus.cipher_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow_set: got %b required 1", bus.overflow); end
      checks++;
      if (bus.word_idx !== 2'd1) begin errors++; $display("FAIL drop_idx_kept: got %0d required 1", bus.word_idx); end
      tick();
      drain(to);
      checks++;
      if (to) begin errors++; $display("FAIL drop_timeout: got out_valid stuck required drained"); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL drop_leftover: got %0d pending required 0", sb_q.size()); end
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow_sticky: got %b required 1", bus.overflow); end
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL drop_overflow_clear: got %b required 0", bus.overflow); end
      tick();
      // A drop and a clear in the same cycle must leave the flag set.
      start(C1, RA);
      bus.out_ready     = 1'b0;
      bus.cipher_valid  = 1'b1;
      bus.clr_ovf       = 1'b1;
      bus.sh_ciphertext = share(C2, RA);
      tick();
      bus.cipher_valid = 1'b0;
      bus.clr_ovf      = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drop_set_wins: got %b required 1", bus.overflow); end
      tick();
      drain(to);
      checks++;
      if (to) begin errors++; $display("FAIL drop2_timeout: got out_valid stuck required drained"); end
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit to;
      start(C1, RA);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b required 0", bus.out_valid); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (bus.sh_word !== WW'(0)) begin errors++; $display("FAIL rstmid_sh_word: got %h required 0", bus.sh_word); end
      sb_q.delete();
      tick();
      start(C2, RA);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.word_idx !== 2'd0) begin
         errors++; $display("FAIL rstmid_restart: got valid=%b idx=%0d required valid=1 idx=0", bus.out_valid, bus.word_idx);
      end
      tick();
      drain(to);
      checks++;
      if (to) begin errors++; $display("FAIL rstmid_timeout: got out_valid stuck required drained"); end
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL rstmid_leftover: got %0d pending required 0", sb_q.size()); end
      tick();
   endtask

   task automatic test_shares();
      logic [127:0] r;
      int n;
      for (int run = 0; run < 3; run++) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         start(C1, r);
         n = 0;
         while (bus.out_valid !== 1'b0 && n < 40) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
         bus.out_ready = 1'b1;
         checks++;
         if (n >= 40) begin errors++; $display("FAIL shares_timeout: got out_valid stuck required drained (run %0d)", run); end
         checks++;
         if (sb_q.size() != 0) begin errors++; $display("FAIL shares_leftover: got %0d pending required 0", sb_q.size()); end
         sb_q.delete();
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_shares();
      tick();
      checks += sb_checks;
      errors += sb_errors;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mskaes_out_serializer.md
Name: mskaes_out_serializer

Overview:
- Downstream stage of the 128-bit masked AES core.
- The core presents sh_ciphertext for exactly one cycle, qualified by cipher_valid, and has no output backpressure. This block captures that sharing and holds it.
- It then emits the sharing as NW words of W bits, still masked, over a valid/ready stream.
- Shares are never combined. The datapath is registers and share-wise muxes only, so the core's PINI property is kept.

Parameters:
- d, 2, number of shares (masking order + 1).
- W, 32, unmasked bits per output word; 128 % W must equal 0.
- NW, 128/W, words per ciphertext (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- cipher_valid  input  1  core output strobe; one-cycle pulse.
- sh_ciphertext  input  128*d  core ciphertext sharing. Bit i, share j sits at index i*d+j.
- in_ready  output  1  buffer can absorb a ciphertext. Upstream ANDs this into the core's valid_in.
- out_valid  output  1  sh_word is valid.
- out_ready  input  1  sink accepts sh_word.
- sh_word  output  W*d  current word sharing, same interleaved layout.
- word_idx  output  clog2(NW)  index of the current word.
- last  output  1  current word is word NW-1.
- overflow  output  1  sticky: a ciphertext was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (rst high at a clk edge), evaluated before all other events:
  - state=IDLE, cnt=0, buffer=all zeros;
  - out_valid=0, overflow=0, in_ready=1;
  - reset mid-transfer discards the held ciphertext with no further beats.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On cipher_valid: buffer<=sh_ciphertext, cnt<=0, state<=SEND.
  - Output is registered: first out_valid is one cycle after the cipher_valid cycle.
- State SEND:
  - out_valid=1.
  - sh_word = buffer[cnt*W*d +: W*d], so word k carries ciphertext bits [k*W +: W].
  - word_idx=cnt; last=(cnt==NW-1).
- Transfer rule: a beat completes when out_valid && out_ready. sh_word, word_idx and last are stable while out_valid && !out_ready.
- Beat completes with cnt<NW-1: cnt<=cnt+1.
- Beat completes with cnt==NW-1:
  - no cipher_valid that cycle: state<=IDLE, cnt<=0, buffer<=zeros;
  - cipher_valid that cycle: buffer<=sh_ciphertext, cnt<=0, stay SEND (back-to-back, no bubble).
- in_ready in SEND = (cnt==NW-1) && out_ready. This is combinational and lets the final beat release the buffer.
- cipher_valid in SEND that is not a completing final beat:
  - new data is dropped; buffer and cnt are unchanged;
  - overflow<=1.
- Overflow flag:
  - stays set until clr_ovf;
  - clr_ovf and a new drop in the same cycle leaves overflow=1 (set wins).
- sh_word is forced to the zero sharing whenever out_valid=0, so stale shares never sit on the bus.
- Latency: cipher_valid at cycle t gives beat k at cycle t+1+k when out_ready is held high.
- NW=1 (W=128) is legal: cnt is a constant 0 and last=1 always.

Decomposition:
- Shared package mskaes_pkg holds:
  - AES_BLOCK_BITS=128;
  - state encoding localparams ST_IDLE, ST_SEND;
  - the clog2 helper function.
- Buffer: instance of the existing MSKregEn with count=128, enabled on capture or clear.
- Zeroing of sh_word: existing MSKmux plus MSKcst.
- Natural sub-module: mskaes_word_select (pure share-wise word mux, NW:1). Reused by a future input deserializer.

Test Plan:
- Bench settings: d=2, W=32. Ciphertext C=0x3925841d02dc09fbdc118597196a0b32. Share0=R=0xA5A5...A5, share1=C^R.
- Single block, out_ready=1, pulse cipher_valid at cycle t:
  - out_valid in cycles t+1..t+4;
  - unmasked words 0x196a0b32, 0xdc118597, 0x02dc09fb, 0x3925841d;
  - last only on the 4th beat;
  - then sh_word=0 and in_ready=1.
- Backpressure: out_ready low for 3 cycles after beat 1. sh_word and word_idx=1 hold constant; all 4 words are still delivered in order.
- Back-to-back: a second ciphertext C2 is pulsed in the cycle of the final beat of C. C2 word 0 appears the very next cycle, and overflow stays 0.
- Drop: cipher_valid pulsed while cnt=1 and out_ready=0. The remaining beats are still words of C, and overflow=1. Pulsing clr_ovf gives overflow=0 the next cycle.
- Reset mid-SEND, after beat 2: the next cycle has out_valid=0, in_ready=1 and sh_word=0. A new capture starts at word_idx=0.
- Share check: run with a fresh R per run. The unmasked output matches, the raw share0 words equal the R slices, and no cycle shows share0^share1 on a single share lane.
